// File: rtl/pll_rstgen_pkg.sv
// Shared types and helpers for the PLL lock supervisor / reset sequencer.
package pll_rstgen_pkg;

  // Supervisor states, in normal start-up order.
  typedef enum logic [2:0] {
    ST_PWRDN     = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_FILTER    = 3'd2,
    ST_RELEASE   = 3'd3,
    ST_RUN       = 3'd4
  } state_e;

  // Width of the retry counter and its saturation value.
  localparam int                RETRY_W   = 8;
  localparam logic [RETRY_W-1:0] RETRY_MAX = 8'hFF;

  // Counter width able to hold max_count without wrapping.
  function automatic int cnt_width(input int max_count);
    return $clog2(max_count) + 1;
  endfunction

  // Larger of two integers, used when sizing the shared counter.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pll_lock_rstgen_if.sv
// Signal bundle between the PLL supervisor and its surroundings.
// master: the supervisor itself; slave: the PLL wrapper / reset consumers.
interface pll_lock_rstgen_if
  import pll_rstgen_pkg::*;
#(
  parameter int NUM_DOMAINS = 3
) ();

  logic                   lock_i;
  logic                   clr_status_i;
  logic                   pll_pwrdn_n_o;
  logic [NUM_DOMAINS-1:0] dom_rst_n_o;
  logic                   locked_o;
  logic                   lock_lost_o;
  logic [RETRY_W-1:0]     retry_cnt_o;

  modport master (
    input  lock_i,
    input  clr_status_i,
    output pll_pwrdn_n_o,
    output dom_rst_n_o,
    output locked_o,
    output lock_lost_o,
    output retry_cnt_o
  );

  modport slave (
    output lock_i,
    output clr_status_i,
    input  pll_pwrdn_n_o,
    input  dom_rst_n_o,
    input  locked_o,
    input  lock_lost_o,
    input  retry_cnt_o
  );

endinterface

// File: rtl/pll_rstgen_sync.sv
// Two-flop synchronizer with asynchronous active-low reset to 0.
module pll_rstgen_sync (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_r;
  logic sync_r;

  // Capture the asynchronous input and let the first stage settle.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      meta_r <= 1'b0;
      sync_r <= 1'b0;
    end else begin
      meta_r <= d_i;
      sync_r <= meta_r;
    end
  end

  assign q_o = sync_r;

endmodule

// File: rtl/pll_lock_rstgen.sv
// PLL supervisor and staggered reset sequencer on the crystal clock.
// Powers the PLL down, waits for lock (retrying on timeout), optionally
// filters the lock for stability, then releases one reset per domain.
// Optional feature macro: PLL_RSTGEN_LOCK_FILTER_EN (adds the FILTER state).
module pll_lock_rstgen
  import pll_rstgen_pkg::*;
#(
  parameter int NUM_DOMAINS  = 3,
  parameter int PWRDN_CYCLES = 64,
  parameter int LOCK_TIMEOUT = 65536,
  parameter int STAGGER      = 16,
  parameter int LOCK_STABLE  = 256
) (
  input logic               clk_i,
  input logic               rst_n_i,
  pll_lock_rstgen_if.master bus
);

  localparam int REL_CYCLES = STAGGER * NUM_DOMAINS;
`ifdef PLL_RSTGEN_LOCK_FILTER_EN
  localparam int STABLE_MAX = LOCK_STABLE;
`else
  // Without the filter the stability length has no influence on the counter.
  localparam int STABLE_MAX = (LOCK_STABLE > 0) ? 1 : 1;
`endif
  localparam int CNT_MAX = max_int(max_int(PWRDN_CYCLES, LOCK_TIMEOUT),
                                   max_int(REL_CYCLES, STABLE_MAX));
  localparam int CNT_W   = cnt_width(CNT_MAX);

  localparam logic [CNT_W-1:0] CNT_ZERO     = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] PWRDN_LAST   = CNT_W'(PWRDN_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
`ifdef PLL_RSTGEN_LOCK_FILTER_EN
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE - 1);
`endif

  logic                   lk_s;
  state_e                 state_r;
  state_e                 state_nxt_s;
  logic [CNT_W-1:0]       cnt_r;
  logic [CNT_W-1:0]       cnt_nxt_s;
  logic [NUM_DOMAINS-1:0] rel_hit_s;
  logic                   rel_last_s;
  logic [NUM_DOMAINS-1:0] dom_r;
  logic [NUM_DOMAINS-1:0] dom_nxt_s;
  logic                   retry_inc_s;
  logic                   lost_set_s;
  logic                   pwrdn_n_r;
  logic                   locked_r;
  logic                   lost_r;
  logic [RETRY_W-1:0]     retry_r;

  pll_rstgen_sync u_lock_sync (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .d_i     (bus.lock_i),
    .q_o     (lk_s)
  );

  // Decode which domain bit is due for release at the current count.
  always_comb begin
    rel_hit_s = '0;
    for (int k = 0; k < NUM_DOMAINS; k++) begin
      if (cnt_r == CNT_W'(STAGGER * (k + 1) - 1)) begin
        rel_hit_s[k] = 1'b1;
      end else begin
        rel_hit_s[k] = 1'b0;
      end
    end
  end

  assign rel_last_s = rel_hit_s[NUM_DOMAINS-1];

  // Next state, shared counter and domain reset pattern.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    dom_nxt_s   = dom_r;
    retry_inc_s = 1'b0;
    lost_set_s  = 1'b0;
    case (state_r)
      ST_PWRDN: begin
        dom_nxt_s = '0;
        if (cnt_r == PWRDN_LAST) begin
          state_nxt_s = ST_WAIT_LOCK;
          cnt_nxt_s   = CNT_ZERO;
        end else begin
          cnt_nxt_s = cnt_r + CNT_ONE;
        end
      end
      ST_WAIT_LOCK: begin
        dom_nxt_s = '0;
        if (lk_s) begin
`ifdef PLL_RSTGEN_LOCK_FILTER_EN
          state_nxt_s = ST_FILTER;
`else
          state_nxt_s = ST_RELEASE;
`endif
          cnt_nxt_s = CNT_ZERO;
        end else if (cnt_r == TIMEOUT_LAST) begin
          // Lock never came: power-cycle the PLL and count the retry.
          state_nxt_s = ST_PWRDN;
          cnt_nxt_s   = CNT_ZERO;
          retry_inc_s = 1'b1;
        end else begin
          cnt_nxt_s = cnt_r + CNT_ONE;
        end
      end
`ifdef PLL_RSTGEN_LOCK_FILTER_EN
      ST_FILTER: begin
        dom_nxt_s = '0;
        if (!lk_s) begin
          // Lock dropped before it was stable: restart the timeout window.
          state_nxt_s = ST_WAIT_LOCK;
          cnt_nxt_s   = CNT_ZERO;
        end else if (cnt_r == STABLE_LAST) begin
          state_nxt_s = ST_RELEASE;
          cnt_nxt_s   = CNT_ZERO;
        end else begin
          cnt_nxt_s = cnt_r + CNT_ONE;
        end
      end
`endif
      ST_RELEASE: begin
        if (!lk_s) begin
          // Lock loss wins over a release due in the same cycle.
          state_nxt_s = ST_WAIT_LOCK;
          cnt_nxt_s   = CNT_ZERO;
          dom_nxt_s   = '0;
          lost_set_s  = 1'b1;
        end else begin
          dom_nxt_s = dom_r | rel_hit_s;
          if (rel_last_s) begin
            state_nxt_s = ST_RUN;
            cnt_nxt_s   = CNT_ZERO;
          end else begin
            cnt_nxt_s = cnt_r + CNT_ONE;
          end
        end
      end
      ST_RUN: begin
        if (!lk_s) begin
          // The PLL stays powered; only the domains go back into reset.
          state_nxt_s = ST_WAIT_LOCK;
          cnt_nxt_s   = CNT_ZERO;
          dom_nxt_s   = '0;
          lost_set_s  = 1'b1;
        end else begin
          dom_nxt_s = dom_r;
        end
      end
      default: begin
        state_nxt_s = ST_PWRDN;
        cnt_nxt_s   = CNT_ZERO;
        dom_nxt_s   = '0;
      end
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_r <= ST_PWRDN;
      cnt_r   <= CNT_ZERO;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Control outputs registered from the next state so they align with it.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pwrdn_n_r <= 1'b0;
      dom_r     <= '0;
      locked_r  <= 1'b0;
    end else begin
      pwrdn_n_r <= (state_nxt_s != ST_PWRDN);
      dom_r     <= dom_nxt_s;
      locked_r  <= (state_nxt_s == ST_RUN);
    end
  end

  // Sticky status: clear has priority over a same-cycle set or increment.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      lost_r  <= 1'b0;
      retry_r <= {RETRY_W{1'b0}};
    end else if (bus.clr_status_i) begin
      lost_r  <= 1'b0;
      retry_r <= {RETRY_W{1'b0}};
    end else begin
      if (lost_set_s) begin
        lost_r <= 1'b1;
      end
      if (retry_inc_s && (retry_r != RETRY_MAX)) begin
        retry_r <= retry_r + RETRY_W'(1);
      end
    end
  end

  assign bus.pll_pwrdn_n_o = pwrdn_n_r;
  assign bus.dom_rst_n_o   = dom_r;
  assign bus.locked_o      = locked_r;
  assign bus.lock_lost_o   = lost_r;
  assign bus.retry_cnt_o   = retry_r;

endmodule

// File: tb/tb_pll_lock_rstgen.sv
// Self-checking bench for pll_lock_rstgen: constant vector table for the
// start-up / loss sequence, hand-written corner sequences, and randomized
// lock/clear stimulus compared every cycle against a behavioural model.
module tb_pll_lock_rstgen;

  localparam int ND = 3;
  localparam int PC = 4;
  localparam int ST = 2;
  localparam int LT = 20;
  localparam int LS = 8;
`ifdef PLL_RSTGEN_LOCK_FILTER_EN
  localparam bit FILT = 1'b1;
  localparam int F    = LS;
`else
  localparam bit FILT = 1'b0;
  localparam int F    = 0;
`endif

  localparam int P_PD  = 0;
  localparam int P_WL  = 1;
  localparam int P_FI  = 2;
  localparam int P_REL = 3;
  localparam int P_RUN = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pll_lock_rstgen_if #(.NUM_DOMAINS(ND)) bus ();

  pll_lock_rstgen #(
    .NUM_DOMAINS  (ND),
    .PWRDN_CYCLES (PC),
    .LOCK_TIMEOUT (LT),
    .STAGGER      (ST),
    .LOCK_STABLE  (LS)
  ) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Behavioural model: phase plus cycles elapsed since entering it.
  int   m_phase;
  int   m_t;
  int   m_retry;
  bit   m_lost;
  bit   m_hist0;
  bit   m_hist1;

  typedef struct {
    string      name;
    int         cyc;
    logic       lock;
    logic       clr;
    logic       pwrdn;
    logic [2:0] dom;
    logic       locked;
    logic       lost;
    logic [7:0] retry;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(string n, int c, logic lk, logic cl, logic pw,
                              logic [2:0] d, logic lo, logic ls, logic [7:0] r);
    vec_t v;
    v.name = n; v.cyc = c; v.lock = lk; v.clr = cl; v.pwrdn = pw;
    v.dom = d; v.locked = lo; v.lost = ls; v.retry = r;
    return v;
  endfunction

  function automatic logic [13:0] dut_vec();
    return {bus.pll_pwrdn_n_o, bus.dom_rst_n_o, bus.locked_o,
            bus.lock_lost_o, bus.retry_cnt_o};
  endfunction

  function automatic logic [13:0] model_vec();
    int n;
    logic [2:0] d;
    n = m_t / ST;
    if (n > ND) n = ND;
    if (m_phase == P_REL) d = 3'((1 << n) - 1);
    else if (m_phase == P_RUN) d = 3'b111;
    else d = 3'b000;
    return {(m_phase != P_PD), d, (m_phase == P_RUN), m_lost, 8'(m_retry)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = P_PD; m_t = 0; m_retry = 0; m_lost = 1'b0;
    m_hist0 = 1'b0; m_hist1 = 1'b0;
  endtask

  // One clock edge of the specified behaviour; lk is lock_i two edges back.
  task automatic model_step();
    bit lk;
    bit inc;
    bit lost;
    lk = m_hist1; inc = 1'b0; lost = 1'b0;
    case (m_phase)
      P_PD: begin
        m_t++;
        if (m_t == PC) begin m_phase = P_WL; m_t = 0; end
      end
      P_WL: begin
        if (lk) begin m_phase = FILT ? P_FI : P_REL; m_t = 0; end
        else begin
          m_t++;
          if (m_t == LT) begin m_phase = P_PD; m_t = 0; inc = 1'b1; end
        end
      end
      P_FI: begin
        if (!lk) begin m_phase = P_WL; m_t = 0; end
        else begin
          m_t++;
          if (m_t == LS) begin m_phase = P_REL; m_t = 0; end
        end
      end
      P_REL: begin
        if (!lk) begin m_phase = P_WL; m_t = 0; lost = 1'b1; end
        else begin
          m_t++;
          if (m_t == ND * ST) m_phase = P_RUN;
        end
      end
      default: begin
        if (!lk) begin m_phase = P_WL; m_t = 0; lost = 1'b1; end
      end
    endcase
    if (bus.clr_status_i) begin
      m_retry = 0; m_lost = 1'b0;
    end else begin
      if (inc && m_retry < 255) m_retry++;
      if (lost) m_lost = 1'b1;
    end
    m_hist1 = m_hist0;
    m_hist0 = bus.lock_i;
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_step();
    @(negedge clk);
    check("model", 32'(dut_vec()), 32'(model_vec()));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.lock_i = 1'b0;
    bus.clr_status_i = 1'b0;
    model_reset();
    @(negedge clk);
    check("reset_values", 32'(dut_vec()), 32'd0);
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    int done;
    int len;
    rst_n = 1'b0;
    bus.lock_i = 1'b0;
    bus.clr_status_i = 1'b0;
    model_reset();

    // Start-up, release, loss and re-lock; edge numbers from reset release.
    tbl.push_back(mk("pd_hold_e3",   3,     1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 8'd0));
    tbl.push_back(mk("pwrup_e4",     1,     1'b0, 1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 8'd0));
    tbl.push_back(mk("wait_e10",     6,     1'b0, 1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 8'd0));
    tbl.push_back(mk("rel_start",    4 + F, 1'b1, 1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 8'd0));
    tbl.push_back(mk("dom0_up",      1,     1'b1, 1'b0, 1'b1, 3'b001, 1'b0, 1'b0, 8'd0));
    tbl.push_back(mk("dom0_hold",    1,     1'b1, 1'b0, 1'b1, 3'b001, 1'b0, 1'b0, 8'd0));
    tbl.push_back(mk("dom1_up",      1,     1'b1, 1'b0, 1'b1, 3'b011, 1'b0, 1'b0, 8'd0));
    tbl.push_back(mk("dom2_run",     2,     1'b1, 1'b0, 1'b1, 3'b111, 1'b1, 1'b0, 8'd0));
    tbl.push_back(mk("loss_sync",    2,     1'b0, 1'b0, 1'b1, 3'b111, 1'b1, 1'b0, 8'd0));
    tbl.push_back(mk("loss_3rd",     1,     1'b0, 1'b0, 1'b1, 3'b000, 1'b0, 1'b1, 8'd0));
    tbl.push_back(mk("clr_lost",     2,     1'b0, 1'b1, 1'b1, 3'b000, 1'b0, 1'b0, 8'd0));
    tbl.push_back(mk("relock_sync",  2,     1'b1, 1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 8'd0));
    tbl.push_back(mk("relock_dom0",  3 + F, 1'b1, 1'b0, 1'b1, 3'b001, 1'b0, 1'b0, 8'd0));
    tbl.push_back(mk("relock_run",   4,     1'b1, 1'b0, 1'b1, 3'b111, 1'b1, 1'b0, 8'd0));

    do_reset();
    foreach (tbl[i]) begin
      bus.lock_i = tbl[i].lock;
      bus.clr_status_i = tbl[i].clr;
      repeat (tbl[i].cyc) tick();
      check(tbl[i].name, 32'(dut_vec()),
            32'({tbl[i].pwrdn, tbl[i].dom, tbl[i].locked, tbl[i].lost, tbl[i].retry}));
    end
    bus.clr_status_i = 1'b0;

    // Timeout retries, then a clear landing on an increment cycle.
    do_reset();
    repeat (24) tick();
    check("to_retry1", 32'(bus.retry_cnt_o), 32'd1);
    check("to_pwrdn_low", 32'(bus.pll_pwrdn_n_o), 32'd0);
    repeat (3) tick();
    check("to_pwrdn_still_low", 32'(bus.pll_pwrdn_n_o), 32'd0);
    tick();
    check("to_pwrdn_up", 32'(bus.pll_pwrdn_n_o), 32'd1);
    repeat (44) tick();
    check("to_retry3", 32'(bus.retry_cnt_o), 32'd3);
    repeat (23) tick();
    bus.clr_status_i = 1'b1;
    tick();
    bus.clr_status_i = 1'b0;
    check("clr_wins", 32'(bus.retry_cnt_o), 32'd0);
    repeat (24) tick();
    check("retry_after_clr", 32'(bus.retry_cnt_o), 32'd1);

    // Glitchy lock: high 5, low 1, then high.
    do_reset();
    repeat (10) tick();
    bus.lock_i = 1'b1;
    repeat (5) tick();
    bus.lock_i = 1'b0;
    tick();
    bus.lock_i = 1'b1;
    repeat (2) tick();
    check("glitch_lost", 32'(bus.lock_lost_o), FILT ? 32'd0 : 32'd1);
    repeat (10) tick();
    check("glitch_e28", 32'(bus.dom_rst_n_o), FILT ? 32'd0 : 32'd7);
    tick();
    check("glitch_e29", 32'(bus.dom_rst_n_o), FILT ? 32'd1 : 32'd7);

    // Lock loss right after only bit 0 was released.
    do_reset();
    repeat (10) tick();
    bus.lock_i = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      if (bus.dom_rst_n_o == 3'b001) found = 1'b1;
    end
    check("midrel_reached", 32'(found), 32'd1);
    bus.lock_i = 1'b0;
    repeat (3) tick();
    check("midrel_dom", 32'(bus.dom_rst_n_o), 32'd0);
    check("midrel_lost", 32'(bus.lock_lost_o), 32'd1);
    check("midrel_pwr", 32'(bus.pll_pwrdn_n_o), 32'd1);
    repeat (10) tick();
    check("midrel_stays", 32'(bus.dom_rst_n_o), 32'd0);

    // Asynchronous reset while running.
    do_reset();
    repeat (10) tick();
    bus.lock_i = 1'b1;
    repeat (25) tick();
    check("run_locked", 32'(bus.locked_o), 32'd1);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("async_rst", 32'(dut_vec()), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) tick();
    check("post_rst_pwrup", 32'(bus.pll_pwrdn_n_o), 32'd1);

    // Randomized lock pattern and occasional clears against the model.
    do_reset();
    done = 0;
    while (done < 1500) begin
      bus.lock_i = ($urandom_range(0, 3) != 0);
      len = $urandom_range(1, 30);
      for (int i = 0; i < len; i++) begin
        bus.clr_status_i = ($urandom_range(0, 15) == 0);
        tick();
      end
      done += len;
    end
    bus.clr_status_i = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
